// File: rtl/alu_exec_unit_if.sv
// Issue/result bus between the ALU reservation station, the ALU execution unit
// and the CDB arbiter.
interface alu_exec_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [XLEN-1:0]  in_op1;
    logic [XLEN-1:0]  in_op2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    // Reservation station / CDB side
    modport master (
        output in_valid, in_op, in_op1, in_op2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    // Execution unit side
    modport slave (
        input  in_valid, in_op, in_op1, in_op2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Registered ALU execution unit: single-cycle integer ops plus an iterative
// shift-add multiplier, with a one-entry output register drained by the CDB.
module alu_exec_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          flush_in,
    alu_exec_unit_if.slave bus
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);
    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(XLEN - 1);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_SLL  = 4'h5,
        OP_SRL  = 4'h6,
        OP_SRA  = 4'h7,
        OP_SLT  = 4'h8,
        OP_SLTU = 4'h9,
        OP_SEQ  = 4'hA,
        OP_SNE  = 4'hB,
        OP_SGE  = 4'hC,
        OP_SGEU = 4'hD,
        OP_MUL  = 4'hE,
        OP_RSVD = 4'hF
    } op_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_e;

    state_e             state, state_nxt;
    logic [SHAMT_W-1:0] cnt, cnt_nxt;
    logic [XLEN-1:0]    mcand, mcand_nxt;
    logic [XLEN-1:0]    mplier, mplier_nxt;
    logic [XLEN-1:0]    acc, acc_nxt;
    logic [TAG_W-1:0]   mul_tag, mul_tag_nxt;
    logic               out_valid_q, out_valid_nxt;
    logic [XLEN-1:0]    out_result_q, out_result_nxt;
    logic [TAG_W-1:0]   out_tag_q, out_tag_nxt;

    logic               in_ready_c;
    logic               accept_c;
    logic               xfer_c;
    op_e                op_c;
    logic [SHAMT_W-1:0] shamt_c;
    logic               lt_s_c;
    logic               lt_u_c;
    logic               eq_c;
    logic [XLEN-1:0]    alu_c;
    logic [XLEN-1:0]    mul_addend_c;
    logic [XLEN-1:0]    mul_sum_c;

    // Handshake qualifiers; in_ready only opens when the output slot is free or draining
    assign in_ready_c = rst_in && rdy_in && !flush_in && (state == ST_IDLE)
                        && (!out_valid_q || bus.out_ready);
    assign accept_c   = bus.in_valid && in_ready_c;
    assign xfer_c     = out_valid_q && bus.out_ready && rdy_in;

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_tag    = out_tag_q;

    assign op_c    = op_e'(bus.in_op);
    assign shamt_c = bus.in_op2[SHAMT_W-1:0];
    assign lt_s_c  = $signed(bus.in_op1) < $signed(bus.in_op2);
    assign lt_u_c  = bus.in_op1 < bus.in_op2;
    assign eq_c    = bus.in_op1 == bus.in_op2;

    // Multiplier step: add the shifted multiplicand when the current multiplier bit is set
    assign mul_addend_c = mplier[0] ? mcand : '0;
    assign mul_sum_c    = acc + mul_addend_c;

    // Single-cycle result for every non-MUL opcode; compares zero-extend a single bit
    always_comb begin
        alu_c = '0;
        case (op_c)
            OP_ADD:  alu_c = bus.in_op1 + bus.in_op2;
            OP_SUB:  alu_c = bus.in_op1 - bus.in_op2;
            OP_AND:  alu_c = bus.in_op1 & bus.in_op2;
            OP_OR:   alu_c = bus.in_op1 | bus.in_op2;
            OP_XOR:  alu_c = bus.in_op1 ^ bus.in_op2;
            OP_SLL:  alu_c = bus.in_op1 << shamt_c;
            OP_SRL:  alu_c = bus.in_op1 >> shamt_c;
            OP_SRA:  alu_c = $unsigned($signed(bus.in_op1) >>> shamt_c);
            OP_SLT:  alu_c = XLEN'(lt_s_c);
            OP_SLTU: alu_c = XLEN'(lt_u_c);
            OP_SEQ:  alu_c = XLEN'(eq_c);
            OP_SNE:  alu_c = XLEN'(!eq_c);
            OP_SGE:  alu_c = XLEN'(!lt_s_c);
            OP_SGEU: alu_c = XLEN'(!lt_u_c);
            default: alu_c = '0;
        endcase
    end

    // Next-state and datapath update: flush beats freeze, freeze beats normal operation
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        mcand_nxt      = mcand;
        mplier_nxt     = mplier;
        acc_nxt        = acc;
        mul_tag_nxt    = mul_tag;
        out_valid_nxt  = out_valid_q;
        out_result_nxt = out_result_q;
        out_tag_nxt    = out_tag_q;

        if (flush_in) begin
            state_nxt     = ST_IDLE;
            cnt_nxt       = '0;
            out_valid_nxt = 1'b0;
        end else if (rdy_in) begin
            if (xfer_c) begin
                out_valid_nxt = 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        if (op_c == OP_MUL) begin
                            state_nxt   = ST_MUL_BUSY;
                            cnt_nxt     = '0;
                            mcand_nxt   = bus.in_op1;
                            mplier_nxt  = bus.in_op2;
                            acc_nxt     = '0;
                            mul_tag_nxt = bus.in_tag;
                        end else begin
                            out_result_nxt = alu_c;
                            out_tag_nxt    = bus.in_tag;
                            out_valid_nxt  = 1'b1;
                        end
                    end
                end
                ST_MUL_BUSY: begin
                    acc_nxt    = mul_sum_c;
                    mcand_nxt  = mcand << 1;
                    mplier_nxt = mplier >> 1;
                    cnt_nxt    = cnt + SHAMT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state_nxt      = ST_IDLE;
                        cnt_nxt        = '0;
                        out_result_nxt = mul_sum_c;
                        out_tag_nxt    = mul_tag;
                        out_valid_nxt  = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            acc          <= '0;
            mul_tag      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            mcand        <= mcand_nxt;
            mplier       <= mplier_nxt;
            acc          <= acc_nxt;
            mul_tag      <= mul_tag_nxt;
            out_valid_q  <= out_valid_nxt;
            out_result_q <= out_result_nxt;
            out_tag_q    <= out_tag_nxt;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vectors with literal expectations plus a
// cycle-level behavioural model compared on every falling edge.
module tb_alu_exec_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic rdy;
    logic flush;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_exec_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    alu_exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk_in   (clk),
        .rst_in   (rst_n),
        .rdy_in   (rdy),
        .flush_in (flush),
        .bus      (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result straight from the opcode definitions
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return a << sh;
            4'h6: return a >> sh;
            4'h7: return $unsigned($signed(a) >>> sh);
            4'h8: return ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
            4'h9: return (a <  b) ? 32'd1 : 32'd0;
            4'hA: return (a == b) ? 32'd1 : 32'd0;
            4'hB: return (a != b) ? 32'd1 : 32'd0;
            4'hC: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            4'hD: return (a >= b) ? 32'd1 : 32'd0;
            4'hE: return 32'(a * b);
            default: return 32'd0;
        endcase
    endfunction

    // Behavioural model: expected outputs, MUL countdown, and whether data is defined
    bit          m_live  = 1'b0;
    bit          m_ov    = 1'b0;
    bit          m_known = 1'b0;
    int          m_busy  = 0;
    logic [31:0] m_res   = '0;
    logic [3:0]  m_tag   = '0;
    logic [31:0] m_mres  = '0;
    logic [3:0]  m_mtag  = '0;

    // Compare the DUT with the model mid-cycle, then advance the model across the next edge
    always @(negedge clk) begin
        bit exp_ready;
        exp_ready = rst_n && rdy && !flush && (m_busy == 0) && (!m_ov || bus.out_ready);
        if (m_live) begin
            check("model_in_ready", 32'(bus.in_ready), 32'(exp_ready));
            check("model_out_valid", 32'(bus.out_valid), 32'(m_ov));
            if (m_known) begin
                check("model_out_result", bus.out_result, m_res);
                check("model_out_tag", 32'(bus.out_tag), 32'(m_tag));
            end
        end
        if (!rst_n) begin
            m_live  = 1'b1;
            m_ov    = 1'b0;
            m_busy  = 0;
            m_res   = '0;
            m_tag   = '0;
            m_known = 1'b1;
        end else if (flush) begin
            m_ov    = 1'b0;
            m_busy  = 0;
            m_known = 1'b0;
        end else if (rdy) begin
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_ov    = 1'b1;
                    m_res   = m_mres;
                    m_tag   = m_mtag;
                    m_known = 1'b1;
                end
            end else begin
                if (m_ov && bus.out_ready) m_ov = 1'b0;
                if (bus.in_valid && exp_ready) begin
                    if (bus.in_op == 4'hE) begin
                        m_busy = XLEN;
                        m_mres = ref_alu(bus.in_op, bus.in_op1, bus.in_op2);
                        m_mtag = bus.in_tag;
                    end else begin
                        m_ov    = 1'b1;
                        m_res   = ref_alu(bus.in_op, bus.in_op1, bus.in_op2);
                        m_tag   = bus.in_tag;
                        m_known = 1'b1;
                    end
                end
            end
        end
    end

    // Present one op and hold it until accepted; returns just after the accepting edge
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
        int n;
        bus.in_op    = op;
        bus.in_op1   = a;
        bus.in_op2   = b;
        bus.in_tag   = tag;
        bus.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) check("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Issue a single-cycle op and pin its result with a literal
    task automatic op_check(input string name, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [3:0] tag, input logic [31:0] exp);
        send(op, a, b, tag);
        check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, "_result"}, bus.out_result, exp);
        check({name, "_tag"}, 32'(bus.out_tag), 32'(tag));
    endtask

    // Count edges from the accepting edge until out_valid rises, bounded
    task automatic wait_valid(input int start, output int lat);
        lat = start;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int lat;
        bit seen;

        vecs[0]  = '{"add_wrap", 4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 4'd3, 32'h0000_0000};
        vecs[1]  = '{"sub_wrap", 4'h1, 32'h0000_0000, 32'h0000_0001, 4'd4, 32'hFFFF_FFFF};
        vecs[2]  = '{"slt",      4'h8, 32'hFFFF_FFFF, 32'h0000_0001, 4'd5, 32'h0000_0001};
        vecs[3]  = '{"sltu",     4'h9, 32'hFFFF_FFFF, 32'h0000_0001, 4'd6, 32'h0000_0000};
        vecs[4]  = '{"sra36",    4'h7, 32'h8000_0000, 32'd36,        4'd8, 32'hF800_0000};
        vecs[5]  = '{"sgeu_eq",  4'hD, 32'd5,         32'd5,         4'd2, 32'h0000_0001};
        vecs[6]  = '{"op_rsvd",  4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 4'd7, 32'h0000_0000};
        vecs[7]  = '{"sll33",    4'h5, 32'h0000_0001, 32'd33,        4'd1, 32'h0000_0002};
        vecs[8]  = '{"srl4",     4'h6, 32'h8000_0000, 32'd4,         4'd9, 32'h0800_0000};
        vecs[9]  = '{"and",      4'h2, 32'h0000_F0F0, 32'h0000_FF00, 4'd10, 32'h0000_F000};
        vecs[10] = '{"or",       4'h3, 32'h0000_F0F0, 32'h0000_FF00, 4'd11, 32'h0000_FFF0};
        vecs[11] = '{"xor",      4'h4, 32'h0000_F0F0, 32'h0000_FF00, 4'd12, 32'h0000_0FF0};
        vecs[12] = '{"seq",      4'hA, 32'd7,         32'd7,         4'd13, 32'h0000_0001};
        vecs[13] = '{"sne",      4'hB, 32'd7,         32'd7,         4'd14, 32'h0000_0000};
        vecs[14] = '{"sge_neg",  4'hC, 32'hFFFF_FFFF, 32'h0000_0001, 4'd15, 32'h0000_0000};
        vecs[15] = '{"sgeu_big", 4'hD, 32'hFFFF_FFFF, 32'h0000_0001, 4'd0, 32'h0000_0001};

        rst_n         = 1'b0;
        rdy           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_op1    = '0;
        bus.in_op2    = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_result", bus.out_result, 32'd0);
        check("rst_out_tag", 32'(bus.out_tag), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Single-cycle opcode vectors
        foreach (vecs[i]) op_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                                   vecs[i].tag, vecs[i].exp);

        // Three back-to-back ADDs, then two cycles of back-pressure
        for (int i = 0; i < 3; i++) begin
            bus.in_op    = 4'h0;
            bus.in_op1   = 32'(i + 1);
            bus.in_op2   = 32'd10;
            bus.in_tag   = 4'(i);
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("b2b_valid", 32'(bus.out_valid), 32'd1);
            check("b2b_result", bus.out_result, 32'(11 + i));
        end
        bus.in_op1    = 32'd100;
        bus.in_op2    = 32'd5;
        bus.in_tag    = 4'd5;
        bus.out_ready = 1'b0;
        #1;
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("bp_hold_result", bus.out_result, 32'd13);
            check("bp_hold_tag", 32'(bus.out_tag), 32'd2);
            check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp_resume_result", bus.out_result, 32'd105);
        check("bp_resume_tag", 32'(bus.out_tag), 32'd5);

        // Multiplies: exactly XLEN edges from accept to result
        send(4'hE, 32'h0001_0003, 32'd7, 4'd9);
        wait_valid(0, lat);
        check("mul_latency", 32'(lat), 32'd32);
        check("mul_result", bus.out_result, 32'h0007_0015);
        check("mul_tag", 32'(bus.out_tag), 32'd9);
        send(4'hE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd11);
        wait_valid(0, lat);
        check("mul_ones_latency", 32'(lat), 32'd32);
        check("mul_ones_result", bus.out_result, 32'h0000_0001);

        // Flush ten cycles into a multiply
        send(4'hE, 32'd3, 32'd3, 4'd6);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("flush_no_result", 32'(seen), 32'd0);

        // Flush coinciding with a presented op drops it
        bus.in_op    = 4'h0;
        bus.in_op1   = 32'd1;
        bus.in_op2   = 32'd1;
        bus.in_tag   = 4'd4;
        bus.in_valid = 1'b1;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_drop_valid", 32'(bus.out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("flush_drop_valid_later", 32'(bus.out_valid), 32'd0);

        // Five-cycle freeze in the middle of a multiply
        send(4'hE, 32'd3, 32'd5, 4'd2);
        repeat (10) @(posedge clk);
        #1;
        rdy = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("freeze_in_ready", 32'(bus.in_ready), 32'd0);
        rdy = 1'b1;
        wait_valid(15, lat);
        check("freeze_mul_latency", 32'(lat), 32'd37);
        check("freeze_mul_result", bus.out_result, 32'd15);
        check("freeze_mul_tag", 32'(bus.out_tag), 32'd2);

        // Reset in the middle of a multiply, then a normal op
        send(4'hE, 32'd6, 32'd7, 4'd8);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_result", bus.out_result, 32'd0);
        check("midrst_out_tag", 32'(bus.out_tag), 32'd0);
        rst_n = 1'b1;
        op_check("post_rst_add", 4'h0, 32'd2, 32'd3, 4'd1, 32'd5);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("midrst_no_stale_mul", 32'(seen), 32'd0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop if the sequence ever wedges
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected under 200000", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised, registered successor to the combinational ALU, for the out-of-order RISC-V core.
- Accepts one issued op at a time from the ALU reservation station over a valid/ready handshake.
- Single-cycle ops complete in 1 cycle; MUL runs iteratively over XLEN cycles.
- Result and ROB tag are held in an output register until the CDB arbiter takes them.
- Adds signed/unsigned compares, arithmetic shift, AND, multiply, back-pressure, flush, and a global stall.

Parameters:
- XLEN, 32, datapath width; power of two, ≥8. Local SHAMT_W = log2(XLEN).
- TAG_W, 4, ROB tag width.

Ports:
- clk_in  in  1  clock; all state updates on rising edge.
- rst_in  in  1  synchronous, active-low reset.
- rdy_in  in  1  global enable; when low, all state is frozen.
- flush_in  in  1  mispredict rollback; synchronous.
- in_valid  in  1  op presented.
- in_ready  out  1  unit can accept this cycle (combinational).
- in_op  in  4  opcode.
- in_op1  in  XLEN  operand 1.
- in_op2  in  XLEN  operand 2.
- in_tag  in  TAG_W  ROB destination tag.
- out_valid  out  1  result available.
- out_ready  in  1  CDB accepts result this cycle.
- out_result  out  XLEN  result.
- out_tag  out  TAG_W  tag of result.

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA.
  - 8 SLT (signed), 9 SLTU, A SEQ, B SNE, C SGE (signed), D SGEU. Compares return 1 or 0, zero-extended.
  - E MUL (low XLEN bits of product).
  - F reserved: result 0, completes normally with its tag so the ROB cannot hang.
- Arithmetic: ADD/SUB wrap modulo 2^XLEN. Shift amount = op2[SHAMT_W-1:0]; upper bits ignored.
- States:
  - IDLE: accepting.
  - MUL_BUSY: iterating; counter 0..XLEN-1, one shift-add step per cycle.
  - Output-register occupancy is tracked separately by out_valid.
- Handshakes:
  - Accept occurs at a rising edge with in_valid && in_ready && rdy_in.
  - in_ready = rst_in && rdy_in && !flush_in && state==IDLE && (!out_valid || out_ready).
  - Output transfer occurs at an edge with out_valid && out_ready && rdy_in.
- Single-cycle op accepted at edge E: out_result/out_tag/out_valid load at E. Latency 1, throughput 1/cycle while out_ready=1.
- MUL accepted at edge E: state enters MUL_BUSY and the tag is latched. Result loads and out_valid rises at edge E+XLEN; state returns to IDLE at the same edge. in_ready stays low throughout.
- If the output register is still full when MUL finishes, MUL cannot have started; the in_ready rule guarantees an empty or draining slot.
- Transfer and new accept on the same edge: the new result replaces the old one and out_valid stays 1.
- Transfer with no new result: out_valid clears. out_result/out_tag keep their last values.
- While out_valid && !out_ready, out_result and out_tag are stable.
- Priority, highest first:
  1. rst_in low.
  2. flush_in.
  3. rdy_in low (freeze).
  4. Normal operation.
- flush_in high at an edge: out_valid←0, state←IDLE, MUL aborted (no result ever emitted), any simultaneous in_valid dropped. Data registers need not clear.
- Reset (rst_in low at an edge): state IDLE, counter 0, out_valid 0, out_result 0, out_tag 0. Mid-MUL reset discards the operation. in_ready is 0 while rst_in is low.
- rdy_in low: no accept, no transfer, MUL counter holds; outputs hold their values.

Test Plan:
- XLEN=32. ADD 0xFFFFFFFF+1, tag 3 → next cycle out_valid=1, result 0x00000000, tag 3. SUB 0−1 → 0xFFFFFFFF.
- SLT(0xFFFFFFFF,1) → 1; SLTU same → 0; SRA 0x80000000 by 36 → 0xF8000000; SGEU(5,5) → 1; op F → 0 with its tag.
- Three back-to-back ADDs, out_ready=1 → results on 3 consecutive cycles. Then out_ready low for 2 cycles → result/tag held, in_ready=0; transfer resumes on the third cycle.
- MUL 0x00010003×7, tag 9 → out_valid rises exactly 32 edges after accept, result 0x00070015, in_ready low meanwhile. MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
- flush_in pulsed 10 cycles into MUL → out_valid never rises, in_ready=1 next cycle. flush_in with in_valid on the same edge → op dropped, no output.
- rdy_in low for 5 cycles mid-MUL → result appears 5 cycles later, same value. rst_in low mid-MUL → out_valid=0, result/tag 0, next op accepted normally.
